// File: rtl/tdm_delay_sum.sv
`default_nettype none
// ============================================================================
// Module      : tdm_delay_sum
// Description : Delay-and-sum beamforming stage. Each TDM frame of SLOTS
//               signed mic samples is written into per-channel circular
//               buffers. Every channel is tapped at its own programmable
//               frame delay, and the taps are summed at full precision.
// Ports       : clk_in         - system clock
//               rst_in         - synchronous, active-low reset
//               audio_in       - one frame of signed samples, index = slot
//               audio_valid_in - single-cycle frame strobe
//               delay_in       - requested per-channel delay in frames
//               delay_load_in  - captures delay_in into the shadow register
//               sum_out        - signed sum of the delayed samples
//               sum_valid_out  - single-cycle strobe, two cycles after the frame
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_delay_sum #(
    parameter  int BIT_WIDTH   = 24,
    parameter  int SLOTS       = 4,
    parameter  int MAX_DELAY   = 32,
    parameter  int DELAY_WIDTH = 5,
    localparam int SUM_WIDTH   = BIT_WIDTH + $clog2(SLOTS)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [SLOTS-1:0][BIT_WIDTH-1:0]     audio_in,
    input  logic                                audio_valid_in,
    input  logic [SLOTS-1:0][DELAY_WIDTH-1:0]   delay_in,
    input  logic                                delay_load_in,
    output logic signed [SUM_WIDTH-1:0]         sum_out,
    output logic                                sum_valid_out
);

    localparam logic [DELAY_WIDTH:0] c_fill_max = (DELAY_WIDTH+1)'(MAX_DELAY);

    logic [DELAY_WIDTH-1:0]              r_wptr;
    logic [DELAY_WIDTH:0]                r_fill;
    logic [SLOTS-1:0][DELAY_WIDTH-1:0]   r_active;
    logic [SLOTS-1:0][DELAY_WIDTH-1:0]   r_shadow;
    logic                                r_pending;
    logic [SLOTS-1:0][DELAY_WIDTH-1:0]   w_delay_eff;
    logic [BIT_WIDTH-1:0]                w_tap [SLOTS];
    logic [BIT_WIDTH-1:0]                r_tap [SLOTS];
    logic                                r_tap_valid;
    logic signed [SUM_WIDTH-1:0]         w_sum;
    logic signed [SUM_WIDTH-1:0]         r_sum;
    logic                                r_sum_valid;

    // A pending load takes effect on the very frame that consumes it, so the
    // delays used for the current read come straight from the shadow copy.
    // A load coincident with a frame is not yet pending and therefore does
    // not affect that frame.
    assign w_delay_eff = r_pending ? r_shadow : r_active;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_chan
            logic [BIT_WIDTH-1:0]   r_mem [MAX_DELAY];
            logic [DELAY_WIDTH-1:0] w_d;
            logic [DELAY_WIDTH-1:0] w_rd_addr;
            logic [BIT_WIDTH-1:0]   w_ch_tap;

            assign w_d       = w_delay_eff[gi];
            // Modulo-MAX_DELAY subtraction falls out of the pointer width.
            assign w_rd_addr = r_wptr - w_d;

            // Buffer storage is never cleared; the fill count below keeps
            // unwritten or pre-reset entries out of the sum.
            always_ff @(posedge clk_in) begin
                if (audio_valid_in) begin
                    r_mem[r_wptr] <= audio_in[gi];
                end
            end

            // Delay 0 bypasses the buffer; a delay reaching further back than
            // the frames written since reset reads as silence.
            assign w_ch_tap = (w_d == '0)               ? audio_in[gi] :
                              ({1'b0, w_d} > r_fill)    ? '0           :
                                                          r_mem[w_rd_addr];
            assign w_tap[gi] = w_ch_tap;
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wptr      <= '0;
            r_fill      <= '0;
            r_active    <= '0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            r_tap_valid <= 1'b0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            if (audio_valid_in) begin
                r_wptr   <= r_wptr + DELAY_WIDTH'(1);
                r_active <= w_delay_eff;
                if (r_fill != c_fill_max) begin
                    r_fill <= r_fill + (DELAY_WIDTH+1)'(1);
                end
            end
            if (delay_load_in) begin
                r_shadow  <= delay_in;
                r_pending <= 1'b1;
            end else if (audio_valid_in) begin
                r_pending <= 1'b0;
            end
            r_tap_valid <= audio_valid_in;
            r_sum_valid <= r_tap_valid;
            if (r_tap_valid) begin
                r_sum <= w_sum;
            end
        end
    end

    // Tap registers are pure datapath; their qualifier r_tap_valid is reset.
    always_ff @(posedge clk_in) begin
        if (audio_valid_in) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_tap[i] <= w_tap[i];
            end
        end
    end

    // Sign-extend every tap to the full sum width before adding.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_sum = w_sum + SUM_WIDTH'($signed(r_tap[i]));
        end
    end

    assign sum_out       = r_sum;
    assign sum_valid_out = r_sum_valid;

endmodule
`default_nettype wire

// File: doc/tdm_delay_sum.md
Name: tdm_delay_sum

Overview:
- Delay-and-sum beamforming stage directly downstream of the TDM microphone receiver.
- Consumes one frame of SLOTS signed mic samples per valid strobe.
- Delays each channel by a programmable integer number of frames using per-channel circular buffers, then emits the full-precision signed sum.
- Output feeds the downstream audio output/decimation path.

Parameters:
- BIT_WIDTH, 24, width of each signed two's-complement mic sample.
- SLOTS, 4, number of mic channels per frame.
- MAX_DELAY, 32, buffer depth in frames. Power of two; legal delays are 0..MAX_DELAY-1.
- DELAY_WIDTH, 5, $clog2(MAX_DELAY).
- SUM_WIDTH, BIT_WIDTH+$clog2(SLOTS), width of the output sum (derived, not overridden).

Ports:
- clk_in  input  1  100MHz system clock.
- rst_in  input  1  synchronous, active-low reset.
- audio_in  input  BIT_WIDTH x [SLOTS]  signed samples of one frame, index = slot.
- audio_valid_in  input  1  single-cycle strobe; audio_in is valid this cycle.
- delay_in  input  DELAY_WIDTH x [SLOTS]  requested per-channel delay in frames.
- delay_load_in  input  1  single-cycle strobe; captures delay_in into a shadow register.
- sum_out  output  SUM_WIDTH  signed sum of delayed samples.
- sum_valid_out  output  1  single-cycle strobe; sum_out is valid this cycle.

Behaviour:
- Reset (rst_in==0 at a clk_in edge):
  - sum_out=0, sum_valid_out=0.
  - Write pointer=0, fill count=0.
  - Active and shadow delays all 0; pending-load flag=0.
  - Buffer RAM contents are not cleared.
- Reset mid-operation aborts any in-flight frame. No sum_valid_out is produced for it.
- Frame write: on audio_valid_in, audio_in[i] is written to buffer i at the write pointer. Then:
  - The write pointer increments modulo MAX_DELAY.
  - The fill count saturates at MAX_DELAY.
- Delayed read: for channel i with active delay d, the tap is the sample written d frames before the current one.
  - d=0 returns the current audio_in[i] via bypass, not the RAM.
  - If d > (fill count before this write), the tap is 0. No stale RAM data may ever reach the sum.
- Pipeline, fully pipelined (back-to-back audio_valid_in accepted every cycle):
  - Stage 1 (cycle of valid+1): registered taps.
  - Stage 2 (valid+2): taps sign-extended to SUM_WIDTH and summed into sum_out; sum_valid_out=1 for exactly one cycle.
  - Latency: exactly 2 clk_in cycles from audio_valid_in to sum_valid_out.
  - sum_out holds its value between strobes.
- Delay update:
  - delay_load_in captures delay_in into the shadow register and sets the pending flag.
  - On the first audio_valid_in in a cycle strictly after the load, shadow is copied to active, the pending flag clears, and that frame already uses the new delays. All channels switch atomically on a frame boundary.
  - If delay_load_in and audio_valid_in coincide, that frame uses the old active delays; the new delays apply from the next frame.
  - A second load before any frame overwrites the shadow (last write wins).
- Arithmetic:
  - Exact signed addition; no saturation or truncation.
  - SUM_WIDTH guarantees no overflow for SLOTS full-scale inputs.
- Wrap-around: pointer arithmetic (wptr - d) is modulo MAX_DELAY. Delays up to MAX_DELAY-1 remain correct indefinitely after the pointer wraps.
- No state machine beyond the fill count and pending flag. The block is always ready; there is no backpressure.

Test Plan:
- Reset then 5 frames with all delays 0, audio_in={1,2,3,4}×frame index -> sum_valid_out exactly 2 cycles after each strobe; sums 10,20,30,40,50; sum_out=0 and sum_valid_out=0 during reset.
- Load delays {0,1,2,3}, feed a 1000 impulse on all channels in frame 0, zeros after -> sums 1000,1000,1000,1000 in frames 0-3 (one channel each), 0 thereafter. Frames before the fill count reaches d contribute 0, not RAM garbage.
- Full-scale: all channels -2^23 (0x800000) with delay 0 -> sum_out=-2^25 in 26-bit signed; all +0x7FFFFF -> 0x1FFFFFC. No wrap.
- Delay 31 on slot 0, ramp input 0..99 for 100 frames (pointer wraps 3×) -> slot-0 contribution equals input from 31 frames earlier from frame 31 onward, 0 before.
- delay_load_in coincident with audio_valid_in (old delay 0, new 2) -> that frame uses delay 0; the next frame uses delay 2. A second load before any frame -> last value wins.
- Back-to-back audio_valid_in for 8 consecutive cycles -> 8 consecutive sum_valid_out cycles, correct sums in order. rst_in asserted mid-burst -> no further valid, and the fill count restarts (taps read 0).
